// File: rtl/cpu_rmw_sequencer_if.sv
// Memory bus between the read-modify-write sequencer (master) and memory (slave).
// Read data returns one cycle after the read strobe.
interface cpu_rmw_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport master (
    output mem_addr,
    output mem_rd,
    output mem_wr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    input  mem_wr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/cpu_rmw_sequencer.sv
// 6502 read-modify-write sequencer: read operand, run the ALU, optional dummy write of the
// original value, write the result back, then hand N/Z/C to the status register.
module cpu_rmw_sequencer #(
  parameter int ADDR_W      = 16,
  parameter bit DUMMY_WRITE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [3:0]        start_op,
  input  logic              start_cin,
  output logic              busy,
  output logic              done,
  output logic              err,

  cpu_rmw_sequencer_if.master bus,

  output logic [7:0]        alu_a,
  output logic [3:0]        alu_op,
  output logic              alu_cin,
  input  logic [7:0]        alu_result,
  input  logic              alu_carry,
  input  logic              alu_neg,
  input  logic              alu_zero,

  output logic              flag_nz_we,
  output logic              flag_c_we,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_c
);

  localparam logic [3:0] OP_ASL = 4'h5;
  localparam logic [3:0] OP_DEC = 4'hA;
  localparam logic [3:0] OP_INC = 4'h9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_DUMMY,
    S_WRITE,
    S_DONE,
    S_REJ
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        op_q;
  logic              cin_q;
  logic [7:0]        operand_q;
  logic [7:0]        result_q;
  logic              flag_n_q, flag_z_q, flag_c_q;

  logic              op_legal;
  logic              op_incdec;
  logic              accept;

  assign op_legal  = (start_op >= OP_ASL) && (start_op <= OP_DEC);
  assign op_incdec = (op_q == OP_INC) || (op_q == OP_DEC);
  assign accept    = (state_q == S_IDLE) && start && op_legal;

  // Next-state logic.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned,
  // which is what keeps synthesis from inferring a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = op_legal ? S_READ : S_REJ;
      S_READ:  state_d = S_LATCH;
      S_LATCH: state_d = DUMMY_WRITE ? S_DUMMY : S_WRITE;
      S_DUMMY: state_d = S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_REJ:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of statement order.
  // NOTE: the reset clears every datapath register too, since operand/result/flags are
  // visible on outputs and must read 0 after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      op_q      <= '0;
      cin_q     <= 1'b0;
      operand_q <= '0;
      result_q  <= '0;
      flag_n_q  <= 1'b0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= start_addr;
        op_q   <= start_op;
        cin_q  <= start_cin;
      end
      // Read data and the ALU response to it are both captured at the end of LATCH.
      if (state_q == S_LATCH) begin
        operand_q <= bus.mem_rdata;
        result_q  <= alu_result;
        flag_n_q  <= alu_neg;
        flag_z_q  <= alu_zero;
        flag_c_q  <= alu_carry;
      end
    end
  end

  // During LATCH the operand register is not yet loaded, so the ALU sees the bus directly;
  // this path feeds only the ALU, never the bus or handshake outputs.
  assign alu_a   = (state_q == S_LATCH) ? bus.mem_rdata : operand_q;
  assign alu_op  = op_q;
  assign alu_cin = cin_q;

  assign flag_n  = flag_n_q;
  assign flag_z  = flag_z_q;
  assign flag_c  = flag_c_q;

  // Bus and handshake outputs decode from registers only.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_wdata = '0;
    busy          = (state_q != S_IDLE);
    done          = 1'b0;
    err           = 1'b0;
    flag_nz_we    = 1'b0;
    flag_c_we     = 1'b0;
    unique case (state_q)
      S_READ: begin
        bus.mem_addr = addr_q;
        bus.mem_rd   = 1'b1;
      end
      S_LATCH: bus.mem_addr = addr_q;
      S_DUMMY: begin
        bus.mem_addr  = addr_q;
        bus.mem_wr    = 1'b1;
        bus.mem_wdata = operand_q;
      end
      S_WRITE: begin
        bus.mem_addr  = addr_q;
        bus.mem_wr    = 1'b1;
        bus.mem_wdata = result_q;
      end
      S_DONE: begin
        done       = 1'b1;
        flag_nz_we = 1'b1;
        flag_c_we  = !op_incdec;
      end
      S_REJ:   err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_rmw_sequencer.sv
// Bench for cpu_rmw_sequencer: two instances (with and without the dummy write) run the same
// directed vectors against a behavioural ALU and a one-cycle-latency memory.
module tb_cpu_rmw_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic [15:0] start_addr;
  logic [3:0]  start_op;
  logic        start_cin;

  cpu_rmw_sequencer_if #(.ADDR_W(16)) bus_d ();
  cpu_rmw_sequencer_if #(.ADDR_W(16)) bus_n ();

  // Index 0: DUMMY_WRITE=1, index 1: DUMMY_WRITE=0.
  logic       busy [2], done [2], err [2], nz_we [2], c_we [2];
  logic       fn [2], fz [2], fc [2];
  logic [7:0] alu_a [2], alu_result [2];
  logic [3:0] alu_op [2];
  logic       alu_cin [2], alu_carry [2], alu_neg [2], alu_zero [2];

  cpu_rmw_sequencer #(.ADDR_W(16), .DUMMY_WRITE(1'b1)) dut_d (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .start_op(start_op),
    .start_cin(start_cin), .busy(busy[0]), .done(done[0]), .err(err[0]), .bus(bus_d),
    .alu_a(alu_a[0]), .alu_op(alu_op[0]), .alu_cin(alu_cin[0]), .alu_result(alu_result[0]),
    .alu_carry(alu_carry[0]), .alu_neg(alu_neg[0]), .alu_zero(alu_zero[0]),
    .flag_nz_we(nz_we[0]), .flag_c_we(c_we[0]), .flag_n(fn[0]), .flag_z(fz[0]), .flag_c(fc[0])
  );

  cpu_rmw_sequencer #(.ADDR_W(16), .DUMMY_WRITE(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .start_op(start_op),
    .start_cin(start_cin), .busy(busy[1]), .done(done[1]), .err(err[1]), .bus(bus_n),
    .alu_a(alu_a[1]), .alu_op(alu_op[1]), .alu_cin(alu_cin[1]), .alu_result(alu_result[1]),
    .alu_carry(alu_carry[1]), .alu_neg(alu_neg[1]), .alu_zero(alu_zero[1]),
    .flag_nz_we(nz_we[1]), .flag_c_we(c_we[1]), .flag_n(fn[1]), .flag_z(fz[1]), .flag_c(fc[1])
  );

  // Behavioural ALU; INC/DEC drive carry high so a leaked C write would be visible.
  function automatic logic [10:0] alu_f(input logic [7:0] a, input logic [3:0] op, input logic cin);
    logic [7:0] r;
    logic       c;
    r = a;
    c = 1'b0;
    case (op)
      4'h5: {c, r} = {a, 1'b0};
      4'h6: {r, c} = {1'b0, a};
      4'h7: {c, r} = {a, cin};
      4'h8: {r, c} = {cin, a};
      4'h9: begin r = a + 8'd1; c = 1'b1; end
      4'hA: begin r = a - 8'd1; c = 1'b1; end
      default: ;
    endcase
    return {c, r[7], (r == 8'h00), r};
  endfunction

  assign {alu_carry[0], alu_neg[0], alu_zero[0], alu_result[0]} = alu_f(alu_a[0], alu_op[0], alu_cin[0]);
  assign {alu_carry[1], alu_neg[1], alu_zero[1], alu_result[1]} = alu_f(alu_a[1], alu_op[1], alu_cin[1]);

  // Memory: returns mem_val one cycle after a read of exp_addr, filler otherwise.
  logic [7:0]  mem_val  = 8'h00;
  logic [15:0] exp_addr = 16'h0000;
  always @(posedge clk) begin
    bus_d.mem_rdata <= (bus_d.mem_rd && bus_d.mem_addr == exp_addr) ? mem_val : 8'hA5;
    bus_n.mem_rdata <= (bus_n.mem_rd && bus_n.mem_addr == exp_addr) ? mem_val : 8'hA5;
  end

  logic        rd_v [2], wr_v [2];
  logic [15:0] ad_v [2];
  logic [7:0]  wd_v [2];
  assign rd_v[0] = bus_d.mem_rd;    assign rd_v[1] = bus_n.mem_rd;
  assign wr_v[0] = bus_d.mem_wr;    assign wr_v[1] = bus_n.mem_wr;
  assign ad_v[0] = bus_d.mem_addr;  assign ad_v[1] = bus_n.mem_addr;
  assign wd_v[0] = bus_d.mem_wdata; assign wd_v[1] = bus_n.mem_wdata;

  // Cumulative bus/handshake monitor sampled on the falling edge.
  int         tick = 0;
  int         n_rd [2] = '{0, 0}, n_wr [2] = '{0, 0}, n_done [2] = '{0, 0}, n_err [2] = '{0, 0};
  int         n_busy [2] = '{0, 0}, n_nzwe [2] = '{0, 0}, n_cwe [2] = '{0, 0}, n_bad [2] = '{0, 0};
  int         done_t [2] = '{0, 0};
  logic [2:0] dflags [2];
  logic [7:0] wlog [2][256];

  always @(negedge clk) begin
    tick = tick + 1;
    for (int i = 0; i < 2; i++) begin
      if (rd_v[i]) begin
        n_rd[i]++;
        if (ad_v[i] != exp_addr) n_bad[i]++;
      end
      if (wr_v[i]) begin
        wlog[i][n_wr[i] & 255] = wd_v[i];
        n_wr[i]++;
        if (ad_v[i] != exp_addr) n_bad[i]++;
      end
      if (rd_v[i] && wr_v[i]) n_bad[i]++;
      if ((!busy[i] || done[i] || err[i]) &&
          (rd_v[i] || wr_v[i] || ad_v[i] != 16'h0 || wd_v[i] != 8'h0)) n_bad[i]++;
      if (busy[i]) n_busy[i]++;
      if (err[i])  n_err[i]++;
      if (nz_we[i]) n_nzwe[i]++;
      if (c_we[i])  n_cwe[i]++;
      if (done[i]) begin
        n_done[i]++;
        done_t[i] = tick;
        dflags[i] = {fn[i], fz[i], fc[i]};
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_cleared(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s[%0d] handshake", tag, i),
            {31'd0, busy[i] | done[i] | err[i] | nz_we[i] | c_we[i] | rd_v[i] | wr_v[i]}, 32'd0);
      check($sformatf("%s[%0d] regs", tag, i),
            {ad_v[i], alu_a[i], alu_op[i], alu_cin[i], fn[i], fz[i], fc[i]}, 32'd0);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] addr;
    logic        cin;
    logic [7:0]  data;
    int          hold;
    logic        legal;
    logic [7:0]  res;
    logic        n, z, c, c_we;
  } vec_t;

  vec_t vecs [12];

  task automatic run_vec(input vec_t v, input string tag);
    int b_rd [2], b_wr [2], b_done [2], b_err [2], b_busy [2], b_nzwe [2], b_cwe [2], b_bad [2];
    int t0;
    for (int i = 0; i < 2; i++) begin
      b_rd[i] = n_rd[i];     b_wr[i] = n_wr[i];     b_done[i] = n_done[i]; b_err[i] = n_err[i];
      b_busy[i] = n_busy[i]; b_nzwe[i] = n_nzwe[i]; b_cwe[i] = n_cwe[i];   b_bad[i] = n_bad[i];
    end
    @(negedge clk);
    mem_val    = v.data;
    exp_addr   = v.addr;
    start      = 1'b1;
    start_addr = v.addr;
    start_op   = v.op;
    start_cin  = v.cin;
    @(posedge clk);
    t0 = tick;
    repeat (v.hold) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (v.hold == 0) begin
      start_addr = 16'($urandom);
      start_op   = 4'h5;
      start_cin  = ~v.cin;
    end
    repeat (8) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      automatic bit    dw = (i == 0);
      automatic string nm = $sformatf("%s/%s", tag, dw ? "dw1" : "dw0");
      check({nm, " reads"},  n_rd[i] - b_rd[i],     v.legal ? 1 : 0);
      check({nm, " writes"}, n_wr[i] - b_wr[i],     v.legal ? (dw ? 2 : 1) : 0);
      check({nm, " err"},    n_err[i] - b_err[i],   v.legal ? 0 : 1);
      check({nm, " done"},   n_done[i] - b_done[i], v.legal ? 1 : 0);
      check({nm, " busy"},   n_busy[i] - b_busy[i], v.legal ? (dw ? 5 : 4) : 1);
      check({nm, " bus"},    n_bad[i] - b_bad[i],   0);
      check({nm, " nz_we"},  n_nzwe[i] - b_nzwe[i], v.legal ? 1 : 0);
      check({nm, " c_we"},   n_cwe[i] - b_cwe[i],   (v.legal && v.c_we) ? 1 : 0);
      if (v.legal) begin
        if (dw) begin
          check({nm, " wdata0"}, wlog[i][b_wr[i] & 255],       v.data);
          check({nm, " wdata1"}, wlog[i][(b_wr[i] + 1) & 255], v.res);
        end else begin
          check({nm, " wdata0"}, wlog[i][b_wr[i] & 255], v.res);
        end
        check({nm, " done_cycle"}, done_t[i] - t0, dw ? 5 : 4);
        check({nm, " nz"}, dflags[i][2:1], {v.n, v.z});
        if (v.c_we) check({nm, " c"}, dflags[i][0], v.c);
      end
    end
  endtask

  initial begin
    int b_done0;
    rst_n      = 1'b0;
    start      = 1'b0;
    start_addr = 16'h0;
    start_op   = 4'h0;
    start_cin  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_cleared("reset");
    rst_n = 1'b1;

    //          op     addr      cin   data   hold legal res    n     z     c     c_we
    vecs[0]  = '{4'h5, 16'h0200, 1'b0, 8'h81, 0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{4'h8, 16'h1234, 1'b1, 8'h01, 0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{4'h9, 16'h00FF, 1'b0, 8'hFF, 0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{4'hA, 16'hFFFF, 1'b0, 8'h00, 0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{4'h6, 16'h0300, 1'b1, 8'h01, 0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{4'h7, 16'h0400, 1'b1, 8'h80, 0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{4'h7, 16'h8001, 1'b0, 8'h40, 0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{4'h6, 16'h00AA, 1'b1, 8'hFE, 0, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{4'h0, 16'h0500, 1'b0, 8'h33, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{4'hF, 16'h0600, 1'b1, 8'h44, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{4'h5, 16'h0210, 1'b0, 8'h40, 4, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{4'h9, 16'h7FFE, 1'b1, 8'h7F, 0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0};

    for (int k = 0; k < 12; k++) run_vec(vecs[k], $sformatf("v%0d", k));

    // Reset while the DUMMY_WRITE=1 instance is in its WRITE cycle.
    b_done0 = n_done[0];
    @(negedge clk);
    mem_val    = 8'h81;
    exp_addr   = 16'h0200;
    start      = 1'b1;
    start_addr = 16'h0200;
    start_op   = 4'h5;
    start_cin  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid in_write", {31'd0, wr_v[0]}, 32'd1);
    check("rst_mid wdata", {24'd0, wd_v[0]}, 32'h02);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mid dw1 mem_wr", {31'd0, wr_v[0]}, 32'd0);
    check("rst_mid dw1 busy", {31'd0, busy[0]}, 32'd0);
    check("rst_mid dw1 we", {30'd0, nz_we[0], c_we[0]}, 32'd0);
    check_cleared("rst_mid");
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_mid dw1 no_done", n_done[0] - b_done0, 0);

    run_vec(vecs[0], "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
